pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4: cycles a multiply occupies EX (legal 2..15).
REQ-002 SHALL have parameter CNT_W, default 32: width of the stall counter.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports id_rn and id_rm, input, 5 bits each: source register numbers of the instruction in ID.
REQ-006 SHALL have ports id_use_rn and id_use_rm, input, 1 bit each: the ID instruction actually reads that source.
REQ-007 SHALL have port ex_rd, input, 5 bits: destination register of the instruction in EX.
REQ-008 SHALL have port ex_load, input, 1 bit: the EX instruction is a load.
REQ-009 SHALL have port id_mul, input, 1 bit: the ID instruction is a multiply.
REQ-010 SHALL have port id_br_taken, input, 1 bit: taken indication from the accelerated branch unit.
REQ-011 SHALL have port mem_req, input, 1 bit: MEM holds a load or store.
REQ-012 SHALL have port mem_ready, input, 1 bit: data memory completes this cycle.
REQ-013 SHALL have port stall_clr, input, 1 bit: synchronous clear of stall_count.
REQ-014 SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 bit each: pipeline register enables.
REQ-015 SHALL have ports ifid_flush, idex_bubble and exmem_bubble, output, 1 bit each: load a NOP into that register.
REQ-016 SHALL have port mul_busy, output, 1 bit: FSM is in state MUL.
REQ-017 SHALL have port stall_count, output, CNT_W bits: count of cycles with pc_en=0.

Function
REQ-018 SHALL implement FSM states RUN and MUL, plus a down-counter mcnt of 4 bits.
REQ-019 SHALL define memstall = mem_req & ~mem_ready.
REQ-020 SHALL define ldhaz = ex_load & (ex_rd != 31) & ((id_use_rn & id_rn == ex_rd) | (id_use_rm & id_rm == ex_rd)); X31 never hazards.
REQ-021 SHALL give memstall top priority in any state: all five enables 0, all flush/bubble outputs 0, FSM and mcnt hold.
REQ-022 SHALL, in RUN with ~memstall & ldhaz, drive pc_en=0, ifid_en=0, idex_bubble=1 and all other enables 1, for exactly one cycle per hazard occurrence.
REQ-023 SHALL, in RUN with ~memstall & ~ldhaz, drive all enables 1.
REQ-024 SHALL, in RUN with ~memstall & ~ldhaz & id_br_taken, drive ifid_flush=1.
REQ-025 SHALL suppress ifid_flush whenever ldhaz or memstall is true (branch re-evaluated next cycle).
REQ-026 SHALL, in RUN with ~memstall & ~ldhaz & id_mul, transition to MUL and load mcnt = MUL_LAT-1.
REQ-027 SHALL, when id_mul and id_br_taken are both asserted in that condition, apply the flush and also enter MUL.
REQ-028 SHALL, in MUL with ~memstall, drive pc_en=ifid_en=idex_en=0, exmem_bubble=1 and memwb_en=1.
REQ-029 SHALL, in MUL with ~memstall, decrement mcnt, and return to RUN on the edge where mcnt=1.
REQ-030 SHALL ignore ldhaz, id_br_taken and id_mul while in MUL.
REQ-031 SHALL let the multiply in EX advance in the first RUN cycle after MUL, so total added latency is MUL_LAT-1 cycles plus any memstall cycles.
REQ-032 SHALL increment stall_count on every edge with pc_en=0, saturating at all-ones.
REQ-033 SHALL give stall_clr priority over increment (count becomes 0).
REQ-034 SHALL make all outputs except stall_count and mul_busy combinational from state, mcnt and inputs; these SHALL have no registered latency.

Reset
REQ-035 SHALL, on reset low, immediately force state RUN, mcnt=0 and stall_count=0, including mid-MUL.
REQ-036 SHALL, while reset is low, drive all enables 1, all flush/bubble outputs 0 and mul_busy 0.
REQ-037 SHALL, after reset deasserts, evaluate first at the next rising clk edge.

Verification
REQ-038 SHALL verify: ex_load=1, ex_rd=5, id_rn=5, id_use_rn=1 for 1 cycle -> pc_en=ifid_en=0 and idex_bubble=1 for 1 cycle; stall_count 0->1. Repeat with ex_rd=id_rn=31 -> no stall.
REQ-039 SHALL verify: MUL_LAT=4, id_mul pulse -> mul_busy=1 and exmem_bubble=1 for 3 cycles with pc_en=idex_en=0; RUN on the 4th cycle; stall_count=3.
REQ-040 SHALL verify: mem_req=1, mem_ready=0 for 2 cycles while in MUL with mcnt=2 -> all enables 0 and exmem_bubble=0 during those 2 cycles; MUL lasts 5 cycles total; stall_count=5.
REQ-041 SHALL verify: id_br_taken=1 with ldhaz=1 -> ifid_flush=0; next cycle, hazard gone -> ifid_flush=1 and all enables 1.
REQ-042 SHALL verify: reset low at mcnt=2 -> mul_busy=0 and stall_count=0 immediately, without a clock edge.
REQ-043 SHALL verify: CNT_W=4 with 20 stall cycles -> stall_count holds at 15; stall_clr=1 together with a stall -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard/stall controller for a 5-stage in-order pipeline. It resolves
//   load-use hazards (one bubble into ID/EX), multi-cycle multiplies (EX is
//   held for MUL_LAT cycles), data-memory wait states (whole pipe frozen) and
//   taken branches from the accelerated branch unit (IF/ID flushed). It also
//   counts the cycles in which the PC was held.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   id_rn, id_rm      source registers of the ID instruction
//   id_use_rn/_rm     the ID instruction really reads that source
//   ex_rd, ex_load    destination register and load flag of the EX instruction
//   id_mul            ID instruction is a multiply
//   id_br_taken       taken branch resolved in ID
//   mem_req/mem_ready MEM access pending / completes this cycle
//   stall_clr         synchronous clear of stall_count
//   *_en              pipeline register enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   ifid_flush, idex_bubble, exmem_bubble   load a NOP into that register
//   mul_busy          a multiply is occupying EX
//   stall_count       saturating count of cycles with pc_en = 0
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             id_mul,
  input  logic             id_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             stall_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN = 1'b0, MUL = 1'b1} state_t;

  localparam logic [3:0] MCNT_LOAD = 4'(MUL_LAT - 1);

  state_t           state_reg, state_next;
  logic [3:0]       mcnt_reg, mcnt_next;
  logic [CNT_W-1:0] stall_count_reg;
  logic             memstall;
  logic             ldhaz;

  assign memstall = mem_req & ~mem_ready;

  // X31 is the zero register: a load targeting it never creates a hazard.
  assign ldhaz = ex_load & (ex_rd != 5'd31) &
                 ((id_use_rn & (id_rn == ex_rd)) | (id_use_rm & (id_rm == ex_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      mcnt_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      mcnt_reg  <= mcnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mcnt_next    = mcnt_reg;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (!reset) begin
      // Outputs stay at the free-running defaults while held in reset.
    end else if (memstall) begin
      // Memory wait freezes everything, including the multiply countdown.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (ldhaz) begin
            // Hold IF/ID; the branch (if any) is re-evaluated next cycle.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else begin
            ifid_flush = id_br_taken;
            if (id_mul) begin
              state_next = MUL;
              mcnt_next  = MCNT_LOAD;
            end
          end
        end
        MUL: begin
          // Multiply sits in EX; younger stages wait, EX/MEM gets NOPs.
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_bubble = 1'b1;
          if (mcnt_reg == 4'd1) begin
            state_next = RUN;
            mcnt_next  = 4'd0;
          end else begin
            mcnt_next = mcnt_reg - 4'd1;
          end
        end
        default: begin
          state_next = RUN;
          mcnt_next  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_reg <= '0;
    end else if (stall_clr) begin
      stall_count_reg <= '0;
    end else if (!pc_en && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign mul_busy    = (state_reg == MUL);
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl. The stimulus process pushes
// the hand-computed expected outputs of each cycle into a queue; a monitor
// samples the DUT on the falling edge and compares against the queue head.
// A second instance with CNT_W=4 shares all inputs to check counter saturation.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic id_use_rn, id_use_rm, ex_load, id_mul, id_br_taken;
  logic mem_req, mem_ready, stall_clr;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_bubble, exmem_bubble, mul_busy;
  logic [31:0] stall_count;

  logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic s_ifid_flush, s_idex_bubble, s_exmem_bubble, s_mul_busy;
  logic [3:0] s_stall_count;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .ex_rd(ex_rd),
    .ex_load(ex_load), .id_mul(id_mul), .id_br_taken(id_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .stall_clr(stall_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .mul_busy(mul_busy), .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .ex_rd(ex_rd),
    .ex_load(ex_load), .id_mul(id_mul), .id_br_taken(id_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .stall_clr(stall_clr),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
    .exmem_en(s_exmem_en), .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .exmem_bubble(s_exmem_bubble),
    .mul_busy(s_mul_busy), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector: {pc, ifid, idex, exmem, memwb, flush, idex_b, exmem_b, busy}
  localparam logic [8:0] RUN_ALL = 9'b11111_000_0;
  localparam logic [8:0] LDH     = 9'b00111_010_0;
  localparam logic [8:0] FLUSH   = 9'b11111_100_0;
  localparam logic [8:0] MULC    = 9'b00011_001_1;
  localparam logic [8:0] MS_RUN  = 9'b00000_000_0;
  localparam logic [8:0] MS_MUL  = 9'b00000_000_1;

  typedef struct {
    string       name;
    logic [8:0]  ctrl;
    logic [31:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;
  logic [31:0] exp_cnt   = 0;
  logic [3:0]  exp_cnt_s = 0;

  // Monitor: every falling edge with a pending expectation is one transaction.
  initial begin
    exp_t e;
    logic [8:0] act, act_s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        act   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_bubble, exmem_bubble, mul_busy};
        act_s = {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
                 s_ifid_flush, s_idex_bubble, s_exmem_bubble, s_mul_busy};
        tests += 3;
        if (act !== e.ctrl || act_s !== e.ctrl) begin
          errors++;
          $display("[TB] FAIL %s ctrl: got %b / %b, expected %b", e.name, act, act_s, e.ctrl);
        end
        if (stall_count !== e.cnt) begin
          errors++;
          $display("[TB] FAIL %s stall_count: got %0d, expected %0d", e.name, stall_count, e.cnt);
        end
        if (s_stall_count !== e.cnt_s) begin
          errors++;
          $display("[TB] FAIL %s stall_count(w4): got %0d, expected %0d", e.name, s_stall_count, e.cnt_s);
        end
        $display("[TB] %-14s ctrl=%b cnt=%0d cnt4=%0d", e.name, act, stall_count, s_stall_count);
      end
    end
  end

  task automatic idle();
    id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; ex_load = 1'b0;
    id_mul = 1'b0; id_br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; stall_clr = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rn, input logic use_rn);
    ex_load = 1'b1; ex_rd = rd; id_rn = rn; id_use_rn = use_rn;
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic step(input string name, input logic [8:0] ctrl);
    exp_t e;
    if (!reset) begin
      exp_cnt = 0; exp_cnt_s = 0;
    end
    e.name = name; e.ctrl = ctrl; e.cnt = exp_cnt; e.cnt_s = exp_cnt_s;
    exp_q.push_back(e);
    @(posedge clk);
    if (!reset || stall_clr) begin
      exp_cnt = 0; exp_cnt_s = 0;
    end else if (!ctrl[8]) begin
      exp_cnt = exp_cnt + 1;
      if (exp_cnt_s != 4'd15) exp_cnt_s = exp_cnt_s + 1;
    end
    #1;
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(posedge clk); #1;

    // Reset held low: hazard inputs must not affect outputs.
    set_load(5'd5, 5'd5, 1'b1); id_br_taken = 1'b1;
    step("rst_hold", RUN_ALL);
    reset = 1'b1;
    step("idle", RUN_ALL);

    // Load-use hazards.
    set_load(5'd5, 5'd5, 1'b1);                 step("ldhaz_rn", LDH);
    step("after_ldhaz", RUN_ALL);
    set_load(5'd31, 5'd31, 1'b1);               step("x31_nohaz", RUN_ALL);
    ex_load = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; id_use_rm = 1'b1;
    step("ldhaz_rm", LDH);
    ex_load = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; step("rm_unused", RUN_ALL);
    set_load(5'd9, 5'd9, 1'b1); id_br_taken = 1'b1;
    step("br_ldhaz", LDH);
    id_br_taken = 1'b1;                          step("br_flush", FLUSH);

    // Multiply: three MUL cycles, inputs ignored while busy.
    id_mul = 1'b1;                               step("mul_issue", RUN_ALL);
    step("mul_c3", MULC);
    set_load(5'd3, 5'd3, 1'b1); id_br_taken = 1'b1; id_mul = 1'b1;
    step("mul_c2_ign", MULC);
    step("mul_c1", MULC);
    step("mul_done", RUN_ALL);

    stall_clr = 1'b1;                            step("clr", RUN_ALL);

    // Multiply stretched by two memory wait cycles at mcnt=2.
    id_mul = 1'b1;                               step("mul2_issue", RUN_ALL);
    step("mul2_c3", MULC);
    mem_req = 1'b1;                              step("mul2_ms1", MS_MUL);
    mem_req = 1'b1;                              step("mul2_ms2", MS_MUL);
    step("mul2_c2", MULC);
    step("mul2_c1", MULC);
    step("mul2_done", RUN_ALL);

    // Memory stall in RUN suppresses flush; ready completes normally.
    mem_req = 1'b1; id_br_taken = 1'b1;          step("ms_run_br", MS_RUN);
    mem_req = 1'b1; mem_ready = 1'b1;            step("mem_ready", RUN_ALL);

    // Multiply issued together with a taken branch.
    id_mul = 1'b1; id_br_taken = 1'b1;           step("mul_br", FLUSH);
    step("mulbr_c3", MULC);
    step("mulbr_c2", MULC);
    step("mulbr_c1", MULC);
    step("mulbr_done", RUN_ALL);

    // Asynchronous reset in the middle of a multiply (mcnt=2).
    id_mul = 1'b1;                               step("mul3_issue", RUN_ALL);
    step("mul3_c3", MULC);
    reset = 1'b0;                                step("rst_mid_mul", RUN_ALL);
    reset = 1'b1;                                step("post_rst", RUN_ALL);

    // Saturation of the 4-bit counter, then clear together with a stall.
    for (int i = 0; i < 20; i++) begin
      mem_req = 1'b1;                            step("sat_stall", MS_RUN);
    end
    step("sat_check", RUN_ALL);
    mem_req = 1'b1; stall_clr = 1'b1;            step("clr_w_stall", MS_RUN);
    step("after_clr", RUN_ALL);

    @(negedge clk); #1;
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
